// File: rtl/demux1xn_stream_if.sv
// Stream bundle for demux1xn_stream: one input stream fanned out to N lanes
// plus the round-robin pointer and drop counter status outputs.
interface demux1xn_stream_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
);
  logic [W-1:0]   in;
  logic           in_valid;
  logic           in_ready;
  logic [SW-1:0]  s;
  logic           rr_en;
  logic [N*W-1:0] y;
  logic [N-1:0]   y_valid;
  logic [N-1:0]   y_ready;
  logic [SW-1:0]  rr_ptr;
  logic [7:0]     err_cnt;

  // The demux itself sits on the slave side.
  modport slave (
    input  in, in_valid, s, rr_en, y_ready,
    output in_ready, y, y_valid, rr_ptr, err_cnt
  );

  modport master (
    output in, in_valid, s, rr_en, y_ready,
    input  in_ready, y, y_valid, rr_ptr, err_cnt
  );
endinterface

// File: rtl/demux1xn_stream.sv
// Registered 1-to-N stream demultiplexer with select or round-robin routing;
// each lane owns a one-entry output register and drains independently.
module demux1xn_stream #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
) (
  input logic              clk,
  input logic              rst,
  demux1xn_stream_if.slave bus
);
  localparam logic [SW:0]   N_EXT   = (SW + 1)'(N);
  localparam logic [SW-1:0] LAST_RR = SW'(N - 1);

  logic [N*W-1:0] y_q, y_d;
  logic [N-1:0]   y_valid_q, y_valid_d;
  logic [SW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  logic [SW-1:0]  tgt;
  logic           tgt_in_range;
  logic [N-1:0]   lane_sel;
  logic [N-1:0]   lane_can_take;
  logic           accept;

  assign tgt          = bus.rr_en ? rr_ptr_q : bus.s;
  assign tgt_in_range = ({1'b0, tgt} < N_EXT);

  // A full lane still accepts when its consumer drains on the same edge.
  assign lane_can_take = ~y_valid_q | bus.y_ready;
  assign bus.in_ready  = tgt_in_range ? |(lane_sel & lane_can_take) : 1'b1;
  assign accept        = bus.in_valid & bus.in_ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic load;
      assign lane_sel[gi]        = tgt_in_range && (tgt == SW'(gi));
      assign load                = accept & lane_sel[gi];
      assign y_valid_d[gi]       = load | (y_valid_q[gi] & ~bus.y_ready[gi]);
      assign y_d[gi*W +: W]      = load ? bus.in : y_q[gi*W +: W];
    end
  endgenerate

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    err_cnt_d = err_cnt_q;
    if (accept && bus.rr_en) begin
      rr_ptr_d = (rr_ptr_q == LAST_RR) ? '0 : rr_ptr_q + 1'b1;
    end
    // Pointer never leaves 0..N-1, so drops can only come from select mode.
    if (accept && !tgt_in_range && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= '0;
      rr_ptr_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      rr_ptr_q  <= rr_ptr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.rr_ptr  = rr_ptr_q;
  assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_demux1xn_stream.sv
// Directed bench for demux1xn_stream: a 4-lane instance for routing,
// backpressure, mode switch and reset, and a 3-lane instance for drops.
module tb_demux1xn_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux1xn_stream_if #(.N(4), .W(8), .SW(2)) b4 ();
  demux1xn_stream_if #(.N(3), .W(8), .SW(2)) b3 ();

  demux1xn_stream #(.N(4), .W(8), .SW(2)) u4 (.clk(clk), .rst(rst), .bus(b4));
  demux1xn_stream #(.N(3), .W(8), .SW(2)) u3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [7:0] lane4(input int i);
    return b4.y[i*8 +: 8];
  endfunction

  initial begin
    b4.in = '0; b4.in_valid = 1'b0; b4.s = '0; b4.rr_en = 1'b0; b4.y_ready = 4'hF;
    b3.in = '0; b3.in_valid = 1'b0; b3.s = '0; b3.rr_en = 1'b0; b3.y_ready = 3'h7;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("rst_yvalid", 32'(b4.y_valid), 32'h0);
    chk("rst_y", 32'(b4.y), 32'h0);
    chk("rst_ptr", 32'(b4.rr_ptr), 32'h0);
    chk("rst_err", 32'(b3.err_cnt), 32'h0);

    // Select mode, single beat to lane 2
    b4.rr_en = 1'b0; b4.s = 2'd2; b4.in = 8'hA1; b4.in_valid = 1'b1;
    settle();
    chk("t1_rdy", 32'(b4.in_ready), 32'h1);
    tick();
    b4.in_valid = 1'b0;
    chk("t1_yvalid", 32'(b4.y_valid), 32'h4);
    chk("t1_lane2", 32'(lane4(2)), 32'hA1);
    settle();
    chk("t1_rdy2", 32'(b4.in_ready), 32'h1);
    tick();
    chk("t1_drain", 32'(b4.y_valid), 32'h0);
    chk("t1_hold", 32'(lane4(2)), 32'hA1);

    // Round-robin burst of five beats: lanes 0,1,2,3,0
    b4.rr_en = 1'b1; b4.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b4.in = 8'h10 + 8'(i);
      settle();
      chk("t2_ptr", 32'(b4.rr_ptr), 32'(i % 4));
      chk("t2_rdy", 32'(b4.in_ready), 32'h1);
      tick();
      chk("t2_yvalid", 32'(b4.y_valid), 32'(1 << (i % 4)));
      chk("t2_data", 32'(lane4(i % 4)), 32'h10 + 32'(i));
    end
    b4.in_valid = 1'b0;
    chk("t2_ptr_end", 32'(b4.rr_ptr), 32'h1);
    tick();

    // Backpressure in select mode on lane 1
    b4.rr_en = 1'b0; b4.s = 2'd1; b4.y_ready = 4'b1101;
    b4.in = 8'h31; b4.in_valid = 1'b1;
    tick();
    chk("t3_first", 32'(lane4(1)), 32'h31);
    chk("t3_yvalid", 32'(b4.y_valid), 32'h2);
    b4.in = 8'h32;
    settle();
    chk("t3_stall", 32'(b4.in_ready), 32'h0);
    tick();
    chk("t3_held", 32'(lane4(1)), 32'h31);
    b4.y_ready = 4'hF;
    settle();
    chk("t3_rdy", 32'(b4.in_ready), 32'h1);
    tick();
    chk("t3_yv_stay", 32'(b4.y_valid), 32'h2);
    chk("t3_second", 32'(lane4(1)), 32'h32);
    b4.in_valid = 1'b0;
    tick();
    chk("t3_drain", 32'(b4.y_valid), 32'h0);

    // Backpressure in round-robin mode: pointer must freeze on full lane 2
    b4.y_ready = 4'b1011; b4.rr_en = 1'b0; b4.s = 2'd2;
    b4.in = 8'h40; b4.in_valid = 1'b1;
    tick();
    b4.rr_en = 1'b1; b4.in = 8'h41;
    tick();
    chk("t3r_lane1", 32'(lane4(1)), 32'h41);
    chk("t3r_ptr", 32'(b4.rr_ptr), 32'h2);
    b4.in = 8'h42;
    settle();
    chk("t3r_stall", 32'(b4.in_ready), 32'h0);
    tick(); tick();
    chk("t3r_frozen", 32'(b4.rr_ptr), 32'h2);
    chk("t3r_held", 32'(lane4(2)), 32'h40);
    b4.y_ready = 4'hF;
    tick();
    chk("t3r_ptr_adv", 32'(b4.rr_ptr), 32'h3);
    chk("t3r_lane2", 32'(lane4(2)), 32'h42);
    b4.in_valid = 1'b0;
    tick();

    // Clean restart, then mode switch
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b4.rr_en = 1'b1; b4.in_valid = 1'b1;
    b4.in = 8'h51; tick();
    b4.in = 8'h52; tick();
    chk("t5_ptr2", 32'(b4.rr_ptr), 32'h2);
    b4.rr_en = 1'b0; b4.s = 2'd0;
    for (int i = 0; i < 3; i++) begin
      b4.in = 8'h53 + 8'(i);
      tick();
      chk("t5_yvalid", 32'(b4.y_valid), 32'h1);
      chk("t5_lane0", 32'(lane4(0)), 32'h53 + 32'(i));
      chk("t5_ptr_hold", 32'(b4.rr_ptr), 32'h2);
    end
    b4.rr_en = 1'b1; b4.in = 8'h56;
    tick();
    chk("t5_resume", 32'(b4.y_valid), 32'h4);
    chk("t5_lane2", 32'(lane4(2)), 32'h56);
    chk("t5_ptr3", 32'(b4.rr_ptr), 32'h3);
    b4.in_valid = 1'b0;
    tick();

    // Out-of-range select on the 3-lane instance
    b3.rr_en = 1'b0; b3.s = 2'd3; b3.in = 8'hEE; b3.in_valid = 1'b1;
    settle();
    chk("t4_rdy", 32'(b3.in_ready), 32'h1);
    repeat (3) tick();
    chk("t4_err3", 32'(b3.err_cnt), 32'h3);
    chk("t4_yvalid", 32'(b3.y_valid), 32'h0);
    repeat (252) tick();
    chk("t4_err255", 32'(b3.err_cnt), 32'hFF);
    repeat (8) tick();
    chk("t4_sat", 32'(b3.err_cnt), 32'hFF);
    b3.in_valid = 1'b0;

    // Reset while every lane is full
    b4.rr_en = 1'b1; b4.y_ready = 4'h0; b4.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b4.in = 8'h61 + 8'(i);
      tick();
    end
    b4.in_valid = 1'b0;
    chk("t6_full", 32'(b4.y_valid), 32'hF);
    chk("t6_lane3", 32'(lane4(3)), 32'h61);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_yvalid", 32'(b4.y_valid), 32'h0);
    chk("t6_y", 32'(b4.y), 32'h0);
    chk("t6_ptr", 32'(b4.rr_ptr), 32'h0);
    chk("t6_err", 32'(b3.err_cnt), 32'h0);
    b4.y_ready = 4'hF; b4.in = 8'h71; b4.in_valid = 1'b1;
    tick();
    b4.in_valid = 1'b0;
    chk("t6_post_yv", 32'(b4.y_valid), 32'h1);
    chk("t6_post_d", 32'(lane4(0)), 32'h71);
    chk("t6_post_ptr", 32'(b4.rr_ptr), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
